alu_share_arb: RTL and testbench

- Shares one combinational alu_32 between two requesters: port 0 is the execute stage, port 1 is the branch/address unit.
- Arbitrates round-robin, drives the ALU operand and op inputs, and captures the result in a one-deep response register per requester.
- Each requester receives its own valid/ready response stream, so the single ALU instance can serve both pipelines without structural hazards.

---
 rtl/alu_share_arb.sv | 206 ++++++++++++++++++++
 tb/tb_alu_share_arb.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arb.sv
// alu_share_arb: lets the execute stage (port 0) and the branch/address unit
// (port 1) share one combinational alu_32. A round-robin arbiter picks at most
// one request per cycle and steers its operands onto the ALU. The result lands
// in a one-deep response register owned by the winning port. Each port has an
// independent valid/ready response stream, so one port's backpressure never
// stalls the other.
module alu_share_arb #(
    parameter int                DATA_W = 32,
    parameter int                OP_W   = 6,
    parameter logic [OP_W-1:0]   OP_ADD = 6'h02,
    parameter logic [OP_W-1:0]   OP_SUB = 6'h06
) (
    input  logic                 iClk,
    input  logic                 iReset_n,

    // Requester 0: execute stage
    input  logic                 iReqValid0,
    output logic                 oReqReady0,
    input  logic [DATA_W-1:0]    iA0,
    input  logic [DATA_W-1:0]    iB0,
    input  logic [OP_W-1:0]      iOp0,
    output logic                 oRspValid0,
    input  logic                 iRspReady0,
    output logic [DATA_W-1:0]    oRspALU0,
    output logic                 oRspZero0,
    output logic                 oRspFlag0,

    // Requester 1: branch/address unit
    input  logic                 iReqValid1,
    output logic                 oReqReady1,
    input  logic [DATA_W-1:0]    iA1,
    input  logic [DATA_W-1:0]    iB1,
    input  logic [OP_W-1:0]      iOp1,
    output logic                 oRspValid1,
    input  logic                 iRspReady1,
    output logic [DATA_W-1:0]    oRspALU1,
    output logic                 oRspZero1,
    output logic                 oRspFlag1,

    // Shared alu_32 instance
    output logic [DATA_W-1:0]    oAluA,
    output logic [DATA_W-1:0]    oAluB,
    output logic [OP_W-1:0]      oAluOp,
    input  logic [DATA_W-1:0]    iAluResult,
    input  logic                 iAluZero,
    input  logic                 iAluOverflow,
    input  logic                 iAluUnderflow
);

    // alu_32 keeps its overflow/underflow outputs in internal latches that
    // only refresh on ADD/SUB. For any other op they show a stale value, so
    // only the flag belonging to the current op is passed through.
    function automatic logic f_rsp_flag(
        input logic [OP_W-1:0] op,
        input logic            ovf,
        input logic            unf
    );
        logic flag;
        flag = 1'b0;
        if (op == OP_ADD) begin
            flag = ovf;
        end else if (op == OP_SUB) begin
            flag = unf;
        end
        return flag;
    endfunction

    // Round-robin pointer: index of the port granted most recently.
    logic                r_last;

    // Response registers, one per port.
    logic                r_rsp_vld0_p1;
    logic [DATA_W-1:0]   r_rsp_alu0_p1;
    logic                r_rsp_zero0_p1;
    logic                r_rsp_flag0_p1;
    logic                r_rsp_vld1_p1;
    logic [DATA_W-1:0]   r_rsp_alu1_p1;
    logic                r_rsp_zero1_p1;
    logic                r_rsp_flag1_p1;

    logic                w_free0;
    logic                w_free1;
    logic                w_elig0;
    logic                w_elig1;
    logic                w_gnt0;
    logic                w_gnt1;
    logic                w_flag;

    // ---- p0: arbitration and ALU drive (combinational) ----

    // A slot can accept new data when it is empty or is being drained in this
    // same cycle. This gives back-to-back throughput under a ready consumer.
    assign w_free0 = !r_rsp_vld0_p1 | iRspReady0;
    assign w_free1 = !r_rsp_vld1_p1 | iRspReady1;
    assign w_elig0 = iReqValid0 & w_free0;
    assign w_elig1 = iReqValid1 & w_free1;

    // Round-robin choice: a contested cycle goes to the port that did not win last.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (w_elig0 && w_elig1) begin
            if (r_last) begin
                w_gnt0 = 1'b1;
            end else begin
                w_gnt1 = 1'b1;
            end
        end else begin
            w_gnt0 = w_elig0;
            w_gnt1 = w_elig1;
        end
    end

    assign oReqReady0 = w_gnt0;
    assign oReqReady1 = w_gnt1;

    // Steer the winner onto the ALU. When idle, 0+0 keeps the ALU quiet.
    always_comb begin
        oAluA  = '0;
        oAluB  = '0;
        oAluOp = OP_ADD;
        if (w_gnt0) begin
            oAluA  = iA0;
            oAluB  = iB0;
            oAluOp = iOp0;
        end else if (w_gnt1) begin
            oAluA  = iA1;
            oAluB  = iB1;
            oAluOp = iOp1;
        end
    end

    assign w_flag = f_rsp_flag(oAluOp, iAluOverflow, iAluUnderflow);

    // ---- p1: response registers ----

    // Pointer moves only on a real grant, so idle cycles keep the current order.
    // Reset value 1 lets port 0 win the first contention.
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            r_last <= 1'b1;
        end else if (w_gnt0) begin
            r_last <= 1'b0;
        end else if (w_gnt1) begin
            r_last <= 1'b1;
        end
    end

    // Port 0 slot occupancy: a grant fills it, and a consume with no refill empties it.
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            r_rsp_vld0_p1 <= 1'b0;
        end else if (w_gnt0) begin
            r_rsp_vld0_p1 <= 1'b1;
        end else if (iRspReady0) begin
            r_rsp_vld0_p1 <= 1'b0;
        end
    end

    // Port 0 data is captured only on grant, so it stays stable while the slot waits.
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            r_rsp_alu0_p1  <= '0;
            r_rsp_zero0_p1 <= 1'b0;
            r_rsp_flag0_p1 <= 1'b0;
        end else if (w_gnt0) begin
            r_rsp_alu0_p1  <= iAluResult;
            r_rsp_zero0_p1 <= iAluZero;
            r_rsp_flag0_p1 <= w_flag;
        end
    end

    // Port 1 slot occupancy: a grant fills it, and a consume with no refill empties it.
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            r_rsp_vld1_p1 <= 1'b0;
        end else if (w_gnt1) begin
            r_rsp_vld1_p1 <= 1'b1;
        end else if (iRspReady1) begin
            r_rsp_vld1_p1 <= 1'b0;
        end
    end

    // Port 1 data is captured only on grant, so it stays stable while the slot waits.
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            r_rsp_alu1_p1  <= '0;
            r_rsp_zero1_p1 <= 1'b0;
            r_rsp_flag1_p1 <= 1'b0;
        end else if (w_gnt1) begin
            r_rsp_alu1_p1  <= iAluResult;
            r_rsp_zero1_p1 <= iAluZero;
            r_rsp_flag1_p1 <= w_flag;
        end
    end

    assign oRspValid0 = r_rsp_vld0_p1;
    assign oRspALU0   = r_rsp_alu0_p1;
    assign oRspZero0  = r_rsp_zero0_p1;
    assign oRspFlag0  = r_rsp_flag0_p1;
    assign oRspValid1 = r_rsp_vld1_p1;
    assign oRspALU1   = r_rsp_alu1_p1;
    assign oRspZero1  = r_rsp_zero1_p1;
    assign oRspFlag1  = r_rsp_flag1_p1;

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb. A behavioural alu_32 stand-in closes the ALU loop,
// including the stale overflow/underflow latches. Directed checks cover
// grant and response timing. A per-port scoreboard predicts every response
// from the requester's own operands and compares it when the response is consumed.
module tb_alu_share_arb;

    localparam int          DATA_W  = 32;
    localparam int          OP_W    = 6;
    localparam logic [5:0]  OP_AND  = 6'h00;
    localparam logic [5:0]  OP_OR   = 6'h01;
    localparam logic [5:0]  OP_ADD  = 6'h02;
    localparam logic [5:0]  OP_SUB  = 6'h06;
    localparam logic [5:0]  OP_SLT  = 6'h07;

    logic                iClk = 1'b0;
    logic                iReset_n;
    logic                iReqValid0, iReqValid1;
    logic                oReqReady0, oReqReady1;
    logic [DATA_W-1:0]   iA0, iB0, iA1, iB1;
    logic [OP_W-1:0]     iOp0, iOp1;
    logic                oRspValid0, oRspValid1;
    logic                iRspReady0, iRspReady1;
    logic [DATA_W-1:0]   oRspALU0, oRspALU1;
    logic                oRspZero0, oRspZero1, oRspFlag0, oRspFlag1;
    logic [DATA_W-1:0]   oAluA, oAluB;
    logic [OP_W-1:0]     oAluOp;
    logic [DATA_W-1:0]   iAluResult;
    logic                iAluZero, iAluOverflow, iAluUnderflow;

    int n_vec = 0;
    int n_err = 0;

    // {alu[31:0], zero, flag}
    logic [33:0] q0[$];
    logic [33:0] q1[$];

    always #5 iClk = ~iClk;

    alu_share_arb #(.DATA_W(DATA_W), .OP_W(OP_W), .OP_ADD(OP_ADD), .OP_SUB(OP_SUB)) dut (
        .iClk(iClk), .iReset_n(iReset_n),
        .iReqValid0(iReqValid0), .oReqReady0(oReqReady0),
        .iA0(iA0), .iB0(iB0), .iOp0(iOp0),
        .oRspValid0(oRspValid0), .iRspReady0(iRspReady0),
        .oRspALU0(oRspALU0), .oRspZero0(oRspZero0), .oRspFlag0(oRspFlag0),
        .iReqValid1(iReqValid1), .oReqReady1(oReqReady1),
        .iA1(iA1), .iB1(iB1), .iOp1(iOp1),
        .oRspValid1(oRspValid1), .iRspReady1(iRspReady1),
        .oRspALU1(oRspALU1), .oRspZero1(oRspZero1), .oRspFlag1(oRspFlag1),
        .oAluA(oAluA), .oAluB(oAluB), .oAluOp(oAluOp),
        .iAluResult(iAluResult), .iAluZero(iAluZero),
        .iAluOverflow(iAluOverflow), .iAluUnderflow(iAluUnderflow)
    );

    // alu_32 stand-in: flags refresh only on ADD/SUB and otherwise hold their last value.
    logic        alu_carry, alu_borrow;
    logic        ovf_l = 1'b0;
    logic        unf_l = 1'b0;
    always_comb begin
        alu_carry  = 1'b0;
        alu_borrow = 1'b0;
        iAluResult = '0;
        case (oAluOp)
            OP_ADD: {alu_carry, iAluResult} = {1'b0, oAluA} + {1'b0, oAluB};
            OP_SUB: begin
                iAluResult = oAluA - oAluB;
                alu_borrow = (oAluA < oAluB);
            end
            OP_AND: iAluResult = oAluA & oAluB;
            OP_OR:  iAluResult = oAluA | oAluB;
            OP_SLT: iAluResult = {31'd0, ($signed(oAluA) < $signed(oAluB))};
            default: iAluResult = '0;
        endcase
        iAluZero      = (iAluResult == '0);
        iAluOverflow  = (oAluOp == OP_ADD) ? alu_carry  : ovf_l;
        iAluUnderflow = (oAluOp == OP_SUB) ? alu_borrow : unf_l;
    end

    always @(posedge iClk) begin
        if (oAluOp == OP_ADD) ovf_l <= alu_carry;
        if (oAluOp == OP_SUB) unf_l <= alu_borrow;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Expected response as the requester sees it: flag only for ADD carry / SUB borrow.
    function automatic logic [33:0] exp_rsp(input logic [31:0] a, input logic [31:0] b,
                                            input logic [5:0] op);
        logic [31:0] r;
        logic        f;
        logic        c;
        r = '0;
        f = 1'b0;
        c = 1'b0;
        case (op)
            OP_ADD: begin
                {c, r} = {1'b0, a} + {1'b0, b};
                f = c;
            end
            OP_SUB: begin
                r = a - b;
                f = (a < b);
            end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_SLT: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: r = '0;
        endcase
        return {r, (r == 32'd0), f};
    endfunction

    // Scoreboard: push on grant, pop and compare on consume.
    always @(negedge iClk) begin
        if (iReset_n) begin
            if (oRspValid0 && iRspReady0) begin
                if (q0.size() == 0) chk("sb0_spurious_rsp", 32'd1, 32'd0);
                else begin
                    logic [33:0] e;
                    e = q0.pop_front();
                    chk("sb0_alu",  oRspALU0,  e[33:2]);
                    chk("sb0_zero", oRspZero0, e[1]);
                    chk("sb0_flag", oRspFlag0, e[0]);
                end
            end
            if (oRspValid1 && iRspReady1) begin
                if (q1.size() == 0) chk("sb1_spurious_rsp", 32'd1, 32'd0);
                else begin
                    logic [33:0] e;
                    e = q1.pop_front();
                    chk("sb1_alu",  oRspALU1,  e[33:2]);
                    chk("sb1_zero", oRspZero1, e[1]);
                    chk("sb1_flag", oRspFlag1, e[0]);
                end
            end
            if (oReqReady0) begin
                chk("rdy0_needs_vld", iReqValid0, 1);
                q0.push_back(exp_rsp(iA0, iB0, iOp0));
            end
            if (oReqReady1) begin
                chk("rdy1_needs_vld", iReqValid1, 1);
                q1.push_back(exp_rsp(iA1, iB1, iOp1));
            end
        end
    end

    task automatic next_cyc();
        @(posedge iClk);
        #1;
    endtask

    task automatic idle_inputs();
        iReqValid0 = 0; iReqValid1 = 0;
        iA0 = '0; iB0 = '0; iOp0 = OP_ADD;
        iA1 = '0; iB1 = '0; iOp1 = OP_ADD;
    endtask

    task automatic do_reset();
        next_cyc();
        idle_inputs();
        iReset_n = 0;
        q0.delete();
        q1.delete();
        next_cyc();
        iReset_n = 1;
    endtask

    initial begin
        iReset_n = 0;
        idle_inputs();
        iRspReady0 = 0; iRspReady1 = 0;
        repeat (2) @(posedge iClk);

        // Reset state
        @(negedge iClk);
        chk("rst_vld0",  oRspValid0, 0);
        chk("rst_vld1",  oRspValid1, 0);
        chk("rst_alu0",  oRspALU0, 0);
        chk("rst_alu1",  oRspALU1, 0);
        chk("rst_zf0",   {oRspZero0, oRspFlag0}, 0);
        chk("rst_zf1",   {oRspZero1, oRspFlag1}, 0);
        iReset_n = 1;

        // Single ADD 5+3 on port 0
        next_cyc();
        iReqValid0 = 1; iA0 = 32'd5; iB0 = 32'd3; iOp0 = OP_ADD; iRspReady0 = 1;
        @(negedge iClk);
        chk("t1_rdy0",  oReqReady0, 1);
        chk("t1_alua",  oAluA, 5);
        chk("t1_aluop", oAluOp, OP_ADD);
        next_cyc();
        iReqValid0 = 0;
        @(negedge iClk);
        chk("t1_vld0",  oRspValid0, 1);
        chk("t1_alu0",  oRspALU0, 8);
        chk("t1_zero0", oRspZero0, 0);
        chk("t1_flag0", oRspFlag0, 0);
        next_cyc();
        @(negedge iClk);
        chk("t1_drain0",    oRspValid0, 0);
        chk("t1_hold_alu0", oRspALU0, 8);
        chk("idle_aluop",   oAluOp, OP_ADD);
        chk("idle_alua",    oAluA | oAluB, 0);

        // Round-robin alternation under full load
        do_reset();
        iRspReady0 = 1; iRspReady1 = 1;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) next_cyc();
            iReqValid0 = 1; iA0 = 32'(k + 10); iB0 = 32'd1; iOp0 = OP_ADD;
            iReqValid1 = 1; iA1 = 32'd100; iB1 = 32'(k); iOp1 = OP_SUB;
            @(negedge iClk);
            chk("t2_gnt0", oReqReady0, (k % 2 == 0) ? 1 : 0);
            chk("t2_gnt1", oReqReady1, (k % 2 == 1) ? 1 : 0);
            if (k > 0) begin
                chk("t2_vld0", oRspValid0, (k % 2 == 1) ? 1 : 0);
                chk("t2_vld1", oRspValid1, (k % 2 == 0) ? 1 : 0);
            end
        end
        next_cyc();
        idle_inputs();
        repeat (2) next_cyc();

        // Backpressure on port 0 with port 1 streaming
        do_reset();
        iReqValid0 = 1; iA0 = 32'd7; iB0 = 32'd7; iOp0 = OP_SUB; iRspReady0 = 0;
        iReqValid1 = 1; iA1 = 32'd8; iB1 = 32'd1; iOp1 = OP_OR;  iRspReady1 = 1;
        @(negedge iClk);
        chk("t3_gnt0_first", oReqReady0, 1);
        chk("t3_gnt1_first", oReqReady1, 0);
        for (int j = 0; j < 4; j++) begin
            next_cyc();
            if (j == 0) begin
                iA0 = 32'd1; iB0 = 32'd1; iOp0 = OP_ADD;
            end
            iA1 = 32'(j * 5); iB1 = 32'd3; iOp1 = OP_OR;
            @(negedge iClk);
            chk("t3_blk_rdy0", oReqReady0, 0);
            chk("t3_rdy1",     oReqReady1, 1);
            chk("t3_vld0",     oRspValid0, 1);
            chk("t3_hold_alu0", oRspALU0, 0);
            chk("t3_hold_z0",  oRspZero0, 1);
        end
        next_cyc();
        iRspReady0 = 1;
        @(negedge iClk);
        chk("t3_refill_rdy0", oReqReady0, 1);
        chk("t3_refill_rdy1", oReqReady1, 0);
        next_cyc();
        idle_inputs();
        @(negedge iClk);
        chk("t3_new_vld0", oRspValid0, 1);
        chk("t3_new_alu0", oRspALU0, 2);
        chk("t3_new_z0",   oRspZero0, 0);
        next_cyc();

        // Flag corners: ADD carry, then AND with stale overflow latch
        iReqValid0 = 1; iA0 = 32'hFFFF_FFFF; iB0 = 32'd1; iOp0 = OP_ADD; iRspReady0 = 1;
        @(negedge iClk);
        chk("t4_rdy0", oReqReady0, 1);
        next_cyc();
        iOp0 = OP_AND;
        @(negedge iClk);
        chk("t4_add_alu",  oRspALU0, 32'd0);
        chk("t4_add_zero", oRspZero0, 1);
        chk("t4_add_flag", oRspFlag0, 1);
        next_cyc();
        iA0 = 32'd0; iB0 = 32'd1; iOp0 = OP_SUB;
        @(negedge iClk);
        chk("t4_and_alu",  oRspALU0, 32'd1);
        chk("t4_and_flag", oRspFlag0, 0);
        next_cyc();
        iA0 = 32'd2; iB0 = 32'd9; iOp0 = OP_SLT;
        @(negedge iClk);
        chk("t4_sub_alu",  oRspALU0, 32'hFFFF_FFFF);
        chk("t4_sub_flag", oRspFlag0, 1);
        next_cyc();
        idle_inputs();
        @(negedge iClk);
        chk("t4_slt_alu",  oRspALU0, 32'd1);
        chk("t4_slt_flag", oRspFlag0, 0);
        chk("t4_slt_zero", oRspZero0, 0);
        next_cyc();

        // Asynchronous reset mid-cycle with a pending response
        iReqValid0 = 1; iA0 = 32'd1; iB0 = 32'd2; iOp0 = OP_ADD; iRspReady0 = 0;
        next_cyc();
        idle_inputs();
        @(negedge iClk);
        chk("t5_pend_vld0", oRspValid0, 1);
        #2;
        iReset_n = 0;
        q0.delete();
        q1.delete();
        #1;
        chk("t5_async_vld0", oRspValid0, 0);
        chk("t5_async_alu0", oRspALU0, 0);
        next_cyc();
        iReset_n = 1;
        iReqValid0 = 1; iA0 = 32'd4; iB0 = 32'd4; iOp0 = OP_SUB; iRspReady0 = 1;
        iReqValid1 = 1; iA1 = 32'd6; iB1 = 32'd9; iOp1 = OP_SLT; iRspReady1 = 1;
        @(negedge iClk);
        chk("t5_gnt0_first", oReqReady0, 1);
        chk("t5_gnt1_wait",  oReqReady1, 0);
        next_cyc();
        @(negedge iClk);
        chk("t5_gnt1_next",  oReqReady1, 1);
        next_cyc();
        idle_inputs();
        repeat (3) next_cyc();

        @(negedge iClk);
        chk("sb0_left", q0.size(), 0);
        chk("sb1_left", q1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
